div_stage_skid_reg: RTL and testbench
=====================================

Name: div_stage_skid_reg

Overview:
- Parametrised successor to the divider's per-stage register bundle.
- Carries one divider-stage payload (remainder, divisor, negated divisor, partial remainders, quotient halves, shift, sign/mode flags), packed into a single DATA_W vector by the enclosing stage.
- Adds valid/ready back-pressure, a 2-entry skid buffer for full throughput without a combinational ready path, and a synchronous flush for cancelled divides.
- Sits between consecutive iterative/pipelined stages of the divider.

Parameters:
- DATA_W, 305, payload width. Default is the sum 32+34+34+66+66+32+32+5+1+1+1+1.
- RESET_DATA, 0, value loaded into both data registers on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all held entries.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept; registered.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  downstream payload valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  payload to next stage.
- busy_o  out  1  at least one entry held.

Behaviour:
- Storage: main entry (main_v, main_d) drives the outputs directly; skid entry (skid_v, skid_d) holds overflow.
- Output mapping: out_valid_o = main_v; out_data_o = main_d; busy_o = main_v | skid_v.
- Ready: in_ready_o = ~skid_v, taken from a flop. There is no combinational path from out_ready_i or in_valid_i to in_ready_o.
- Handshakes: acc = in_valid_i & in_ready_o; pop = main_v & out_ready_i.
- Reset (async, rst_n=0): main_v=0, skid_v=0, main_d=skid_d=RESET_DATA. Outputs: out_valid_o=0, in_ready_o=1, busy_o=0, out_data_o=RESET_DATA.
- Reset mid-operation discards all entries immediately. No partial state survives.
- Per-edge update, first matching rule wins:
  1. flush_i=1: main_v<=0, skid_v<=0. Data registers hold; a simultaneous acc is dropped; a simultaneous pop still counts downstream.
  2. skid_v=1 & pop: main_d<=skid_d, main_v<=1, skid_v<=0. Here in_ready_o=0, so acc is impossible.
  3. skid_v=1 & ~pop: hold everything.
  4. main_v=0 & acc: main_d<=in_data_i, main_v<=1.
  5. main_v=1 & pop & acc: main_d<=in_data_i, main_v stays 1.
  6. main_v=1 & pop & ~acc: main_v<=0.
  7. main_v=1 & ~pop & acc: skid_d<=in_data_i, skid_v<=1, so in_ready_o falls next cycle.
  8. Otherwise hold.
- Latency: 1 cycle from acc to out_valid_o when the stage is empty. Throughput: 1 payload/cycle while out_ready_i=1.
- Ordering: strict FIFO. The skid entry always drains before any newer payload.
- Stability: while out_valid_o=1 & out_ready_i=0, out_data_o and out_valid_o must not change except via flush.
- Capacity: max 2 entries. Accept is never lost: when in_ready_o=1 a free slot is guaranteed, because a full skid forces in_ready_o=0.
- Data registers carry no reset dependency beyond the reset value. Width is exactly DATA_W with no sign or zero extension.
- A flush while empty has no effect. A flush concurrent with reset is overridden by reset.
- in_data_i is don't-care when in_valid_i=0 and must never be captured.

Test Plan:
- Reset then idle: out_valid_o=0, in_ready_o=1, busy_o=0, out_data_o=0; stays so with in_valid_i=0 for 10 cycles.
- Streaming: out_ready_i=1, push 0x1,0x2,0x3 on consecutive cycles. Outputs 0x1,0x2,0x3 appear one cycle later on consecutive cycles; in_ready_o stays 1.
- Back-pressure: out_ready_i=0, push 0xA then 0xB.
  - in_ready_o=0 after 0xB; 0xC is held off upstream.
  - out_data_o=0xA stable for 5 cycles.
  - Raise out_ready_i: 0xA, 0xB, 0xC emerge in order with no loss.
- Flush while full: 2 entries held, assert flush_i with in_valid_i=1 and data 0xD. Next cycle out_valid_o=0, busy_o=0, in_ready_o=1, and 0xD is never output.
- Pop+accept same cycle: main holds 0x5, out_ready_i=1, push 0x6. Next cycle out_data_o=0x6, skid stays empty.
- Async reset mid-stream: deassert rst_n between edges with 2 entries held. Outputs drop to reset values without a clock edge; after release, the first new push emerges correctly.

Source files
------------

// File: rtl/div_stage_skid_reg.sv
// Divider per-stage payload register with valid/ready back-pressure and a
// 2-entry skid buffer, so in_ready_o comes straight from a flop.
module div_stage_skid_reg #(
  parameter int unsigned            DATA_W     = 305,
  parameter logic [DATA_W-1:0]      RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o
);

  // Handshake: a payload moves on an edge where valid & ready are both 1.
  // Upstream must not rely on ready combinationally following out_ready_i.

  logic              r_main_v;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;

  logic              w_acc;
  logic              w_pop;
  logic              w_main_v_n;
  logic              w_skid_v_n;
  logic [DATA_W-1:0] w_main_d_n;
  logic [DATA_W-1:0] w_skid_d_n;

  assign in_ready_o  = ~r_skid_v;
  assign out_valid_o = r_main_v;
  assign out_data_o  = r_main_d;
  assign busy_o      = r_main_v | r_skid_v;

  assign w_acc = in_valid_i & in_ready_o;
  assign w_pop = r_main_v & out_ready_i;

  always_comb begin
    w_main_v_n = r_main_v;
    w_skid_v_n = r_skid_v;
    w_main_d_n = r_main_d;
    w_skid_d_n = r_skid_d;
    if (flush_i) begin
      // Data registers hold; only the valid bits are killed.
      w_main_v_n = 1'b0;
      w_skid_v_n = 1'b0;
    end else if (r_skid_v) begin
      if (w_pop) begin
        w_main_d_n = r_skid_d;
        w_main_v_n = 1'b1;
        w_skid_v_n = 1'b0;
      end
    end else if (!r_main_v) begin
      if (w_acc) begin
        w_main_d_n = in_data_i;
        w_main_v_n = 1'b1;
      end
    end else if (w_pop) begin
      if (w_acc) begin
        w_main_d_n = in_data_i;
      end else begin
        w_main_v_n = 1'b0;
      end
    end else if (w_acc) begin
      w_skid_d_n = in_data_i;
      w_skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= RESET_DATA;
      r_skid_d <= RESET_DATA;
    end else begin
      r_main_v <= w_main_v_n;
      r_skid_v <= w_skid_v_n;
      r_main_d <= w_main_d_n;
      r_skid_d <= w_skid_d_n;
    end
  end

endmodule

// File: tb/tb_div_stage_skid_reg.sv
// Bench for div_stage_skid_reg: directed scenarios with literal expectations
// plus a randomized phase checked against a queue model every cycle.
module tb_div_stage_skid_reg;

  localparam int DW = 305;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];

  div_stage_skid_reg #(.DATA_W(DW), .RESET_DATA('0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .busy_o     (busy_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A FIFO of at most two payloads: ready when fewer than two are held,
  // head is presented downstream, flush empties it, reset empties it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush_i) begin
      exp_q.delete();
    end else begin
      bit can_acc;
      can_acc = in_valid_i && (exp_q.size() < 2);
      if (exp_q.size() > 0 && out_ready_i) void'(exp_q.pop_front());
      if (can_acc) exp_q.push_back(in_data_i);
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_out_valid", DW'(out_valid_o), DW'(exp_q.size() > 0));
      check("cmp_in_ready",  DW'(in_ready_o),  DW'(exp_q.size() < 2));
      check("cmp_busy",      DW'(busy_o),      DW'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("cmp_out_data", out_data_o, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, DW'(out_valid_o), '0);
    check({tag, "_ready"}, DW'(in_ready_o),  DW'(1));
    check({tag, "_busy"},  DW'(busy_o),      '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) step();
    check_idle("reset");
    check("reset_data", out_data_o, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("idle");
      check("idle_data", out_data_o, '0);
    end

    // Streaming 1,2,3 with downstream always ready.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      step();
      check("stream_valid", DW'(out_valid_o), DW'(1));
      check("stream_data",  out_data_o, DW'(i));
      check("stream_ready", DW'(in_ready_o), DW'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("stream_drained", DW'(out_valid_o), '0);

    // Back-pressure: A, B fill the stage; C waits upstream.
    drive(1'b1, DW'('hA), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('hB), 1'b0, 1'b0);
    step();
    check("bp_ready_low", DW'(in_ready_o), '0);
    drive(1'b1, DW'('hC), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_data",  out_data_o, DW'('hA));
      check("bp_hold_valid", DW'(out_valid_o), DW'(1));
    end
    drive(1'b1, DW'('hC), 1'b1, 1'b0);
    step();
    check("bp_second", out_data_o, DW'('hB));
    check("bp_ready_back", DW'(in_ready_o), DW'(1));
    step();
    check("bp_third", out_data_o, DW'('hC));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("bp_empty", DW'(out_valid_o), '0);

    // Flush while full, with a concurrent push of D.
    drive(1'b1, DW'('h11), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('h12), 1'b0, 1'b0);
    step();
    check("fl_full_busy", DW'(busy_o), DW'(1));
    drive(1'b1, DW'('hD), 1'b0, 1'b1);
    step();
    check_idle("flush");
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_d", DW'(out_valid_o), '0);
    end

    // Pop and accept on the same edge.
    drive(1'b1, DW'('h5), 1'b1, 1'b0);
    step();
    check("pa_first", out_data_o, DW'('h5));
    drive(1'b1, DW'('h6), 1'b1, 1'b0);
    step();
    check("pa_second", out_data_o, DW'('h6));
    check("pa_skid_empty", DW'(in_ready_o), DW'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Asynchronous reset with two entries held.
    drive(1'b1, DW'('h21), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('h22), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst");
    check("arst_data", out_data_o, '0);
    step();
    rst_n = 1'b1;
    drive(1'b1, DW'('h33), 1'b1, 1'b0);
    step();
    check("arst_after", out_data_o, DW'('h33));
    check("arst_after_v", DW'(out_valid_o), DW'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Randomized traffic; the negedge scoreboard checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) < 60), rand_data(),
            1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 3));
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) step();
    check("final_idle", DW'(busy_o), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
